imm_gen_pipe: RTL and testbench

Parametrised, registered immediate generator for the ID stage of the pipelined RV CPU. Accepts one instruction per cycle over a valid/ready handshake, decodes the immediate format from the opcode, and sign-extends to XLEN. Also precomputes the PC-relative target (pc + imm) and flags unknown opcodes. Results sit in a 2-entry output buffer, so ID can absorb one cycle of EX back-pressure without a combinational ready path from EX to IF.

---
 rtl/imm_gen_pipe_pkg.sv | 30 +++
 rtl/imm_gen_pipe_if.sv | 31 +++
 rtl/imm_gen_pipe_imm_decode.sv | 72 +++++++
 rtl/imm_gen_pipe.sv | 89 ++++++++
 tb/tb_imm_gen_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - shared opcodes, immediate format codes for the ID stage
package imm_gen_pipe_pkg;

   // Major opcodes, inst[6:0]
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   // Immediate format codes, shared with EX and the hazard unit
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } imm_fmt_e;

   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle
interface imm_gen_pipe_if #(
   parameter int XLEN = 32
);
   import imm_gen_pipe_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   imm_fmt_e         out_fmt;
   logic [XLEN-1:0]  out_target;
   logic             out_illegal;

   // Instruction source / result consumer side
   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
   );

   // Immediate generator side
   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
   );

endinterface

// File: rtl/imm_gen_pipe_imm_decode.sv
// rtl/imm_gen_pipe_imm_decode.sv - combinational immediate decode and pc-relative target
module imm_decode
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]      inst,
   input  logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  imm,
   output imm_fmt_e         fmt,
   output logic [XLEN-1:0]  target,
   output logic             illegal
);

   // Immediates are built sign-extended to 64 bits and then truncated,
   // so the same field layouts serve both RV32 and RV64.
   logic [63:0] imm64;
   logic        sgn;

   assign sgn = inst[31];

   // Pick the immediate layout from the major opcode
   always_comb begin
      imm64   = '0;
      fmt     = FMT_R;
      illegal = 1'b0;
      case (inst[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
            fmt   = FMT_I;
            imm64 = {{52{sgn}}, inst[31:20]};
         end
         OPC_OP_IMM_32: begin
            if (XLEN == 64) begin
               fmt   = FMT_I;
               imm64 = {{52{sgn}}, inst[31:20]};
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            fmt   = FMT_S;
            imm64 = {{52{sgn}}, inst[31:25], inst[11:7]};
         end
         OPC_BRANCH: begin
            fmt   = FMT_B;
            imm64 = {{51{sgn}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         OPC_JAL: begin
            fmt   = FMT_J;
            imm64 = {{43{sgn}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt   = FMT_U;
            imm64 = {{32{sgn}}, inst[31:12], 12'b0};
         end
         OPC_OP: begin
            fmt = FMT_R;
         end
         OPC_OP_32: begin
            illegal = (XLEN != 64);
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   assign imm    = imm64[XLEN-1:0];
   // Wraps modulo 2^XLEN; consumers only use it for B, J and AUIPC
   assign target = pc + imm;

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry output buffer
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          reset,
   imm_gen_pipe_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      imm_fmt_e        fmt;
      logic [XLEN-1:0] target;
      logic            illegal;
   } entry_t;

   entry_t      dec_entry;
   entry_t      mem [FIFO_DEPTH];
   entry_t      head;
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;

   imm_decode #(
      .XLEN (XLEN)
   ) u_imm_decode (
      .inst    (bus.in_inst),
      .pc      (bus.in_pc),
      .imm     (dec_entry.imm),
      .fmt     (dec_entry.fmt),
      .target  (dec_entry.target),
      .illegal (dec_entry.illegal)
   );

   // Handshake flags come straight from the registered count, so there is
   // no combinational path from out_ready back to in_ready.
   assign bus.in_ready  = (count != 2'd2);
   assign bus.out_valid = (count != 2'd0);

   // Flush wins over any concurrent transfer
   assign push = bus.in_valid  & bus.in_ready & ~bus.flush;
   assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

   // Occupancy count and ring pointers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else if (bus.flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // Entry storage; contents are don't-care until counted, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= dec_entry;
      end
   end

   // Head entry is forced to zero whenever the buffer is empty
   always_comb begin
      head = '0;
      if (count != 2'd0) begin
         head = mem[rd_ptr];
      end
   end

   assign bus.out_imm     = head.imm;
   assign bus.out_fmt     = head.fmt;
   assign bus.out_target  = head.target;
   assign bus.out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

   typedef struct {
      longint unsigned imm;
      int              fmt;
      longint unsigned target;
      bit              ill;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [63:0] in_pc;
   logic        flush;
   logic        out_ready;

   int total;
   int bad;

   exp_t q32[$];
   exp_t q64[$];

   imm_gen_pipe_if #(.XLEN(32)) if32 ();
   imm_gen_pipe_if #(.XLEN(64)) if64 ();

   assign if32.in_valid  = in_valid;
   assign if32.in_inst   = in_inst;
   assign if32.in_pc     = in_pc[31:0];
   assign if32.flush     = flush;
   assign if32.out_ready = out_ready;
   assign if64.in_valid  = in_valid;
   assign if64.in_inst   = in_inst;
   assign if64.in_pc     = in_pc;
   assign if64.flush     = flush;
   assign if64.out_ready = out_ready;

   imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
   imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .bus(if64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: immediate value from the ISA field layouts, as plain integer arithmetic
   function automatic exp_t ref_decode(input bit [31:0] inst, input longint unsigned pc, input int xlen);
      exp_t            e;
      longint          v;
      longint unsigned mask;
      bit [6:0]        opc;
      bit              s;
      opc   = inst[6:0];
      s     = inst[31];
      mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      e.fmt = 0;
      e.ill = 1'b0;
      v     = 0;
      case (opc)
         7'h13, 7'h03, 7'h67, 7'h73: begin
            e.fmt = 1; v = inst[31:20]; if (s) v -= 4096;
         end
         7'h1B: begin
            if (xlen == 64) begin e.fmt = 1; v = inst[31:20]; if (s) v -= 4096; end
            else e.ill = 1'b1;
         end
         7'h23: begin
            e.fmt = 2; v = inst[31:25] * 32 + inst[11:7]; if (s) v -= 4096;
         end
         7'h63: begin
            e.fmt = 3;
            v = inst[7] * 2048 + inst[30:25] * 32 + inst[11:8] * 2;
            if (s) v -= 4096;
         end
         7'h6F: begin
            e.fmt = 5;
            v = inst[19:12] * 4096 + inst[20] * 2048 + inst[30:21] * 2;
            if (s) v -= 1048576;
         end
         7'h37, 7'h17: begin
            e.fmt = 4; v = longint'(inst[31:12]) * 4096; if (s) v -= 64'h1_0000_0000;
         end
         7'h33: e.fmt = 0;
         7'h3B: e.ill = (xlen != 64);
         default: e.ill = 1'b1;
      endcase
      e.imm    = longint'(v) & mask;
      e.target = (pc + longint'(v)) & mask;
      return e;
   endfunction

   // Advance one clock and update the scoreboards from the handshake seen before the edge
   task automatic tick();
      bit   p32, o32, p64, o64, fl;
      exp_t e32, e64;
      p32 = in_valid && if32.in_ready && !flush;
      o32 = if32.out_valid && out_ready && !flush;
      p64 = in_valid && if64.in_ready && !flush;
      o64 = if64.out_valid && out_ready && !flush;
      fl  = flush;
      e32 = ref_decode(in_inst, {32'b0, in_pc[31:0]}, 32);
      e64 = ref_decode(in_inst, in_pc, 64);
      @(posedge clk);
      #1;
      if (fl) begin
         q32.delete();
         q64.delete();
      end else begin
         if (o32) void'(q32.pop_front());
         if (p32) q32.push_back(e32);
         if (o64) void'(q64.pop_front());
         if (p64) q64.push_back(e64);
      end
   endtask

   task automatic push_one(input logic [31:0] inst, input logic [63:0] pc);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
      #12;
      total++;
      if ({if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready} !== 4'b0101) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=0101", {if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready});
      end
      total++;
      if ({if32.out_imm, if32.out_target, if64.out_imm, if64.out_target} !== '0 ||
          {if32.out_fmt, if32.out_illegal, if64.out_fmt, if64.out_illegal} !== '0) begin
         bad++;
         $display("FAIL reset_outputs imm32=%h imm64=%h fmt32=%0d ill32=%b", if32.out_imm, if64.out_imm, if32.out_fmt, if32.out_illegal);
      end
      reset = 1'b1;
   endtask

   task automatic test_directed();
      out_ready = 1'b1;
      push_one(32'hFFF00093, 64'h100);
      total++;
      if ({if32.out_valid, if32.out_imm, 3'(if32.out_fmt), if32.out_illegal, if32.out_target} !==
          {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h000000FF}) begin
         bad++;
         $display("FAIL addi32 got imm=%h fmt=%0d ill=%b tgt=%h exp imm=ffffffff fmt=1 ill=0 tgt=000000ff",
                  if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_target);
      end
      push_one(32'hFE000EE3, 64'h100);
      total++;
      if ({if32.out_imm, 3'(if32.out_fmt), if32.out_target} !== {32'hFFFFFFFC, 3'd3, 32'h000000FC}) begin
         bad++;
         $display("FAIL beq32 got imm=%h fmt=%0d tgt=%h exp imm=fffffffc fmt=3 tgt=000000fc", if32.out_imm, if32.out_fmt, if32.out_target);
      end
      push_one(32'h0080006F, 64'h200);
      total++;
      if ({if32.out_imm, 3'(if32.out_fmt), if32.out_target} !== {32'h00000008, 3'd5, 32'h00000208}) begin
         bad++;
         $display("FAIL jal32 got imm=%h fmt=%0d tgt=%h exp imm=00000008 fmt=5 tgt=00000208", if32.out_imm, if32.out_fmt, if32.out_target);
      end
      push_one(32'h800002B7, 64'h0);
      total++;
      if ({if64.out_imm, 3'(if64.out_fmt), if64.out_illegal} !== {64'hFFFFFFFF80000000, 3'd4, 1'b0}) begin
         bad++;
         $display("FAIL lui64 got imm=%h fmt=%0d ill=%b exp imm=ffffffff80000000 fmt=4 ill=0", if64.out_imm, if64.out_fmt, if64.out_illegal);
      end
      push_one(32'hFFFFFFFF, 64'h40);
      total++;
      if ({if64.out_imm, 3'(if64.out_fmt), if64.out_illegal} !== {64'h0, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL bad64 got imm=%h fmt=%0d ill=%b exp imm=0 fmt=0 ill=1", if64.out_imm, if64.out_fmt, if64.out_illegal);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      in_pc     = 64'h100;
      in_valid  = 1'b1;
      in_inst   = 32'hFFF00093;
      tick();
      in_inst   = 32'h00500113;
      tick();
      total++;
      if ({if32.in_ready, if32.out_valid} !== 2'b01) begin
         bad++;
         $display("FAIL bp_full got ready=%b valid=%b exp ready=0 valid=1", if32.in_ready, if32.out_valid);
      end
      in_inst = 32'h0080006F;
      tick();
      total++;
      if ({if32.in_ready, if32.out_imm} !== {1'b0, 32'hFFFFFFFF}) begin
         bad++;
         $display("FAIL bp_hold got ready=%b imm=%h exp ready=0 imm=ffffffff", if32.in_ready, if32.out_imm);
      end
      out_ready = 1'b1;
      tick();
      total++;
      if ({if32.out_valid, if32.in_ready, if32.out_imm} !== {2'b11, 32'h00000005}) begin
         bad++;
         $display("FAIL bp_pop_a got valid=%b ready=%b imm=%h exp valid=1 ready=1 imm=00000005", if32.out_valid, if32.in_ready, if32.out_imm);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if ({if32.out_valid, if32.out_imm, 3'(if32.out_fmt)} !== {1'b1, 32'h00000008, 3'd5}) begin
         bad++;
         $display("FAIL bp_third got valid=%b imm=%h fmt=%0d exp valid=1 imm=00000008 fmt=5", if32.out_valid, if32.out_imm, if32.out_fmt);
      end
      tick();
      total++;
      if (if32.out_valid !== 1'b0 || q32.size() != 0) begin
         bad++;
         $display("FAIL bp_drain got valid=%b exp valid=0", if32.out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00100093;
      in_pc     = 64'h300;
      tick();
      tick();
      in_inst = 32'h00200093;
      flush   = 1'b1;
      tick();
      flush   = 1'b0;
      total++;
      if ({if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready, if32.out_imm} !== {4'b0101, 32'h0}) begin
         bad++;
         $display("FAIL flush got v32=%b r32=%b v64=%b r64=%b imm=%h exp 0101 imm=0",
                  if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready, if32.out_imm);
      end
      in_valid = 1'b0;
      tick();
      total++;
      if ({if32.out_valid, if64.out_valid} !== 2'b00) begin
         bad++;
         $display("FAIL flush_drop got v32=%b v64=%b exp 00", if32.out_valid, if64.out_valid);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      out_ready = 1'b0;
      push_one(32'h00700093, 64'h400);
      in_valid = 1'b1;
      in_inst  = 32'h00800093;
      #2;
      reset = 1'b0;
      #1;
      q32.delete();
      q64.delete();
      total++;
      if ({if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready, if32.out_imm} !== {4'b0101, 32'h0}) begin
         bad++;
         $display("FAIL reset_mid got v32=%b r32=%b v64=%b r64=%b imm=%h exp 0101 imm=0",
                  if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready, if32.out_imm);
      end
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      in_inst   = 32'hFE000EE3;
      in_pc     = 64'h1000;
      tick();
      in_valid = 1'b0;
      e = ref_decode(32'hFE000EE3, 64'h1000, 64);
      total++;
      if ({if64.out_valid, if64.out_imm, if64.out_target} !== {1'b1, e.imm, e.target}) begin
         bad++;
         $display("FAIL reset_release got valid=%b imm=%h tgt=%h exp valid=1 imm=%h tgt=%h",
                  if64.out_valid, if64.out_imm, if64.out_target, e.imm, e.target);
      end
      tick();
   endtask

   task automatic test_random();
      bit [6:0]        opcs [13];
      exp_t            e;
      longint unsigned got, want;
      opcs = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h1B, 7'h3B, 7'h7F};
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_inst   = $urandom();
         if ($urandom_range(0, 7) != 0) in_inst[6:0] = opcs[$urandom_range(0, 12)];
         in_pc     = {$urandom(), $urandom()};
         tick();
         total++;
         if ({if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready} !==
             {q32.size() != 0, q32.size() < 2, q64.size() != 0, q64.size() < 2}) begin
            bad++;
            $display("FAIL rand_flags cyc=%0d got=%b exp=%b", c,
                     {if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready},
                     {q32.size() != 0, q32.size() < 2, q64.size() != 0, q64.size() < 2});
         end
         e = (q32.size() != 0) ? q32[0] : '{0, 0, 0, 1'b0};
         got  = {32'b0, if32.out_imm};
         want = e.imm;
         total++;
         if (got !== want || 32'(if32.out_fmt) != e.fmt || if32.out_illegal !== e.ill ||
             {32'b0, if32.out_target} !== e.target) begin
            bad++;
            $display("FAIL rand32 cyc=%0d got imm=%h fmt=%0d ill=%b tgt=%h exp imm=%h fmt=%0d ill=%b tgt=%h", c,
                     if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_target, e.imm, e.fmt, e.ill, e.target);
         end
         e = (q64.size() != 0) ? q64[0] : '{0, 0, 0, 1'b0};
         total++;
         if (if64.out_imm !== e.imm || 32'(if64.out_fmt) != e.fmt || if64.out_illegal !== e.ill ||
             if64.out_target !== e.target) begin
            bad++;
            $display("FAIL rand64 cyc=%0d got imm=%h fmt=%0d ill=%b tgt=%h exp imm=%h fmt=%0d ill=%b tgt=%h", c,
                     if64.out_imm, if64.out_fmt, if64.out_illegal, if64.out_target, e.imm, e.fmt, e.ill, e.target);
         end
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
